hamming_dec_engine: RTL and testbench



---
 rtl/hamming_dec_engine.sv | 142 ++++++++++++++
 tb/tb_hamming_dec_engine.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_dec_engine.sv
// SECDED Hamming(16,11) decoder engine: reads codewords from data memory,
// writes corrected 11-bit messages with error flags back to data memory.
module hamming_dec_engine #(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  output logic          done,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic          mem_wen,
  output logic [7:0]    mem_wdata
);

  localparam int KW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_WORDS - 1);
  localparam logic [AW-1:0] SRC_A  = AW'(SRC_BASE);
  localparam logic [AW-1:0] DST_A  = AW'(DST_BASE);
  localparam logic [AW-1:0] ONE_A  = AW'(1);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, DECODE, WR_LO, WR_HI} state_t;

  function automatic logic [3:0] syndrome(input logic [15:0] cw);
    logic [3:0] s;
    s = '0;
    for (int i = 1; i < 16; i++) begin
      if (cw[i]) s = s ^ 4'(i);
    end
    return s;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] cw);
    return {cw[15:9], cw[7:5], cw[3]};
  endfunction

  // Returns {flags, data}; flags 01 = corrected single error, 10 = double error.
  function automatic logic [12:0] decode(input logic [15:0] cw);
    logic [3:0]  s;
    logic        p;
    logic [15:0] fixed;
    logic [1:0]  flags;
    s     = syndrome(cw);
    p     = ^cw;
    fixed = cw;
    flags = 2'b00;
    if (p) begin
      if (s != 4'd0) fixed[s] = ~fixed[s];
      flags = 2'b01;
    end else if (s != 4'd0) begin
      flags = 2'b10;
    end
    return {flags, extract(fixed)};
  endfunction

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q;
  logic            done_q;
  logic [15:0]     cw_p0;
  logic [10:0]     data_p1;
  logic [1:0]      flags_p1;
  logic [AW-1:0]   k_off, src_lo, dst_lo;

  assign k_off  = AW'({k_q, 1'b0});
  assign src_lo = SRC_A + k_off;
  assign dst_lo = DST_A + k_off;
  assign done   = done_q;

  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    mem_addr  = '0;
    mem_wen   = 1'b0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (req) state_d = RD_LO;
      end
      RD_LO: begin
        mem_addr = src_lo;
        state_d  = RD_HI;
      end
      RD_HI: begin
        mem_addr = src_lo + ONE_A;
        state_d  = DECODE;
      end
      DECODE: state_d = WR_LO;
      WR_LO: begin
        mem_addr  = dst_lo;
        mem_wen   = 1'b1;
        mem_wdata = data_p1[7:0];
        state_d   = WR_HI;
      end
      WR_HI: begin
        mem_addr  = dst_lo + ONE_A;
        mem_wen   = 1'b1;
        mem_wdata = {flags_p1, 3'b000, data_p1[10:8]};
        state_d   = (k_q == K_LAST) ? IDLE : RD_LO;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req) begin
            done_q <= 1'b0;
            k_q    <= '0;
          end
        end
        WR_HI: begin
          if (k_q == K_LAST) done_q <= 1'b1;
          else               k_q    <= k_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Stage p0: codeword capture; stage p1: decoded data and flags.
  always_ff @(posedge clk) begin
    case (state_q)
      RD_LO:   cw_p0[7:0]  <= mem_rdata;
      RD_HI:   cw_p0[15:8] <= mem_rdata;
      DECODE:  {flags_p1, data_p1} <= decode(cw_p0);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Self-checking bench for hamming_dec_engine: memory model, write scoreboard,
// vector table of corrupted codewords and handshake/abort sequences.
module tb_hamming_dec_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic       done, busy, mem_wen;
  logic [7:0] mem_addr, mem_rdata, mem_wdata;

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr] = mem_wdata;
  end

  hamming_dec_engine #(.NUM_WORDS(15), .SRC_BASE(30), .DST_BASE(0), .AW(8)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done), .busy(busy),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wen(mem_wen), .mem_wdata(mem_wdata)
  );

  typedef struct {
    logic [10:0] msg;
    logic [15:0] flip;
    logic [7:0]  exp_lo;
    logic [7:0]  exp_hi;
  } vec_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  vec_t tbl [15];
  wr_t  q [$];
  int   n_pass = 0;
  int   n_total = 0;
  int   wr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference encoder: data into non-power-of-two positions, parity so syndrome is 0.
  function automatic logic [15:0] enc(input logic [10:0] m);
    logic [15:0] c;
    logic        par;
    int          j;
    c = '0;
    j = 0;
    for (int p = 3; p < 16; p++) begin
      if (p != 4 && p != 8) begin
        c[p] = m[j];
        j++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      par = 1'b0;
      for (int p = 3; p < 16; p++) if ((p & (1 << b)) != 0) par = par ^ c[p];
      c[1 << b] = par;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  // Scoreboard: every DUT write is popped and compared.
  always @(negedge clk) begin
    if (mem_wen) begin
      wr_cnt++;
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: addr %0h data %0h with no write expected", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", 32'(mem_wdata), 32'(e.data));
      end
    end
  end

  task automatic load_src();
    logic [15:0] cw;
    for (int k = 0; k < 15; k++) begin
      cw = enc(tbl[k].msg) ^ tbl[k].flip;
      mem[30 + 2*k]     = cw[7:0];
      mem[30 + 2*k + 1] = cw[15:8];
    end
  endtask

  task automatic fill_dst();
    for (int i = 0; i < 30; i++) mem[i] = 8'hEE;
  endtask

  task automatic push_words(input int nw);
    wr_t e;
    for (int k = 0; k < nw; k++) begin
      e.addr = 8'(2*k);     e.data = tbl[k].exp_lo; q.push_back(e);
      e.addr = 8'(2*k + 1); e.data = tbl[k].exp_hi; q.push_back(e);
    end
  endtask

  task automatic check_mem();
    for (int k = 0; k < 15; k++) begin
      check($sformatf("mem_lo[%0d]", k), 32'(mem[2*k]), 32'(tbl[k].exp_lo));
      check($sformatf("mem_hi[%0d]", k), 32'(mem[2*k+1]), 32'(tbl[k].exp_hi));
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic start_pulse();
    @(negedge clk) req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
  endtask

  initial begin
    int n;
    int wr_base;
    tbl[0]  = '{11'h000, 16'h0000, 8'h00, 8'h00};
    tbl[1]  = '{11'h7FF, 16'h0000, 8'hFF, 8'h07};
    tbl[2]  = '{11'h555, 16'h0200, 8'h55, 8'h45};
    tbl[3]  = '{11'h001, 16'h0001, 8'h01, 8'h40};
    tbl[4]  = '{11'h3A5, 16'h1008, 8'h24, 8'h83};
    tbl[5]  = '{11'h7FF, 16'h8000, 8'hFF, 8'h47};
    tbl[6]  = '{11'h000, 16'h0002, 8'h00, 8'h40};
    tbl[7]  = '{11'h2AA, 16'h0100, 8'hAA, 8'h42};
    tbl[8]  = '{11'h000, 16'h0006, 8'h00, 8'h80};
    tbl[9]  = '{11'h123, 16'h0020, 8'h23, 8'h41};
    tbl[10] = '{11'h7FF, 16'h8001, 8'hFF, 8'h83};
    tbl[11] = '{11'h0F0, 16'h0000, 8'hF0, 8'h00};
    tbl[12] = '{11'h456, 16'h0010, 8'h56, 8'h44};
    tbl[13] = '{11'h7FF, 16'h0028, 8'hFC, 8'h87};
    tbl[14] = '{11'h00F, 16'h4000, 8'h0F, 8'h40};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b1;
    req   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wen", 32'(mem_wen), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    @(negedge clk) reset = 1'b0;

    // Single req pulse over the full vector table.
    load_src();
    fill_dst();
    push_words(15);
    start_pulse();
    check("run1_busy", 32'(busy), 32'd1);
    wait_done(n);
    check("run1_latency", 32'(n), 32'd75);
    check("run1_queue", 32'(q.size()), 32'd0);
    check_mem();

    // req held high during the whole run must not extend or restart it.
    fill_dst();
    push_words(15);
    @(negedge clk) req = 1'b1;
    @(posedge clk); #1;
    wait_done(n);
    req = 1'b0;
    check("held_latency", 32'(n), 32'd75);
    @(posedge clk); #1;
    check("held_idle_busy", 32'(busy), 32'd0);
    check("held_done_kept", 32'(done), 32'd1);
    check_mem();

    // Back-to-back: req on the cycle right after done.
    fill_dst();
    push_words(15);
    start_pulse();
    wait_done(n);
    check("b2b_first_latency", 32'(n), 32'd75);
    req = 1'b1;
    fill_dst();
    push_words(15);
    @(posedge clk); #1 req = 1'b0;
    check("b2b_done_clear", 32'(done), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done(n);
    check("b2b_second_latency", 32'(n), 32'd75);
    check("b2b_queue", 32'(q.size()), 32'd0);
    check_mem();

    // Reset during cycle 20 of a run: four words written, then nothing.
    fill_dst();
    push_words(4);
    wr_base = wr_cnt;
    start_pulse();
    repeat (19) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_wen", 32'(mem_wen), 32'd0);
    @(negedge clk) reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("abort_writes", 32'(wr_cnt - wr_base), 32'd8);
    check("abort_queue", 32'(q.size()), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_untouched", 32'(mem[8]), 32'hEE);
    check("abort_last_hi", 32'(mem[7]), 32'(tbl[3].exp_hi));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
